if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the IF/ID register consumer in ID. It owns the 9-bit PC and issues single-outstanding requests to instruction memory over a valid/ready request and valid response interface. It loads the IF/ID slot (Curr_Pc, Curr_Instr, valid) and honours load-use stall from the hazard unit and branch/JAL/JALR redirect from EX.

Parameters:
PC_W, 9, PC and IF/ID Curr_Pc width (byte address)
INSTR_W, 32, instruction width
RESET_PC, 9'h000, PC value after reset
NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous reset, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  PC_W  fetch byte address
imem_rsp_valid  in  1  response data valid (exactly one per accepted request, >=1 cycle later)
imem_rsp_data  in  INSTR_W  fetched instruction
stall  in  1  hold IF/ID contents (load-use)
redirect_valid  in  1  taken branch/jump from EX; flush
redirect_pc  in  PC_W  redirect target
ifid_curr_pc  out  PC_W  IF/ID Curr_Pc
ifid_curr_instr  out  INSTR_W  IF/ID Curr_Instr
ifid_valid  out  1  IF/ID slot holds a real instruction

Behaviour:
- Reset (async, any state): pc=RESET_PC, state=IDLE, drop=0, buffer empty, ifid_valid=0, ifid_curr_instr=NOP_INSTR, ifid_curr_pc=0, imem_req_valid=0.
- Internal regs: pc (next fetch address), req_pc (address of in-flight request), drop flag, one-entry hold buffer {pc,instr}.
- imem_req_valid=1 only in REQ; imem_req_addr=pc (registered state, no input-to-output comb path).
- States:
  IDLE: one cycle after reset -> REQ.
  REQ: on handshake (valid&ready): req_pc<=pc, pc<=pc+4, -> WAIT.
  WAIT: on rsp_valid: if drop -> discard, drop<=0, -> REQ; else if !stall -> load IF/ID {req_pc,data,valid=1}, -> REQ; else store in hold buffer, -> HOLD.
  HOLD: when !stall -> load IF/ID from buffer, -> REQ.
- Peak throughput: one instruction per 2 cycles with 1-cycle memory latency. At most one request outstanding.
- PC arithmetic: pc+4 modulo 2^PC_W (9'h1FC+4 = 9'h000). redirect_pc[1:0] forced to 00.
- IF/ID register update priority: redirect > stall > new instruction > bubble.
  redirect_valid: ifid_valid<=0, instr<=NOP_INSTR, curr_pc<=0.
  stall (no redirect): hold all three IF/ID fields.
  Not stalled and nothing delivered this cycle: ifid_valid<=0, instr<=NOP_INSTR, curr_pc unchanged.
- Redirect per state (pc<=redirect_pc in all cases):
  IDLE -> REQ.
  REQ without handshake: stay REQ.
  REQ with handshake the same cycle: drop<=1, -> WAIT. The old-PC response is discarded.
  WAIT with no rsp this cycle: drop<=1.
  WAIT with rsp the same cycle: the response is discarded, -> REQ.
  HOLD: buffer discarded, -> REQ.
  Redirect overrides stall.
- Stall has no effect on the PC or on request issue in REQ. A response arriving while stalled is buffered, never lost.
- Reset mid-request: any later imem_rsp_valid belonging to the pre-reset request is the memory's responsibility; the memory is reset together with this block.

Test Plan:
- Reset release, 1-cycle memory, always ready: req addrs 0x000,0x004,0x008; IF/ID shows (0x000,I0,v=1), bubble, (0x004,I1,v=1), ... ; ifid_valid=0 and instr=0x00000013 during reset.
- Wrap: redirect_pc=0x1FC -> fetch 0x1FC then next req addr 0x000.
- Stall=1 for 3 cycles while response I5 arrives at pc 0x014: IF/ID holds the prior instruction; state HOLD; I5 appears with Curr_Pc=0x014 the cycle after stall drops; no request issued while in HOLD.
- Redirect to 0x040 in WAIT, response arrives 2 cycles later: response discarded, ifid_valid=0, next req addr 0x040, IF/ID then shows (0x040,...).
- Redirect coincident with REQ handshake at pc 0x020, target 0x100 (and redirect_pc=0x103 variant): 0x020 response dropped; next req addr 0x100 in both cases.
- Redirect and stall asserted together with valid IF/ID: IF/ID flushed (v=0, NOP). imem_req_ready low for 4 cycles: imem_req_valid stays 1, addr stable, PC not advanced.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to
// instruction memory and loads the IF/ID slot, honouring stall and redirect.
module if_fetch_stage #(
    parameter int unsigned              PC_W      = 9,
    parameter int unsigned              INSTR_W   = 32,
    parameter logic [PC_W-1:0]          RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]       NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [PC_W-1:0]     imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [INSTR_W-1:0]  imem_rsp_data,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic [PC_W-1:0]     ifid_curr_pc,
    output logic [INSTR_W-1:0]  ifid_curr_instr,
    output logic                ifid_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t              state;
    logic [PC_W-1:0]     pc;
    logic [PC_W-1:0]     req_pc;
    logic                drop;
    logic [PC_W-1:0]     buf_pc;
    logic [INSTR_W-1:0]  buf_instr;

    logic                handshake;
    logic                deliver_rsp;
    logic                deliver_buf;
    logic [PC_W-1:0]     pc_plus4;
    logic [PC_W-1:0]     redirect_tgt;

    // Request side is decoded from registered state only, so no input
    // reaches imem_req_valid/imem_req_addr combinationally.
    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc;

    assign handshake    = imem_req_valid && imem_req_ready;
    assign pc_plus4     = pc + PC_W'(4);
    assign redirect_tgt = {redirect_pc[PC_W-1:2], 2'b00};
    assign deliver_rsp  = (state == S_WAIT) && imem_rsp_valid && !drop;
    assign deliver_buf  = (state == S_HOLD);

    // Fetch control: PC, in-flight bookkeeping and the one-entry hold buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            req_pc    <= RESET_PC;
            drop      <= 1'b0;
            // NOTE: the buffer is only read in S_HOLD, so its reset just keeps
            // its contents deterministic; occupancy is implied by the state.
            buf_pc    <= '0;
            buf_instr <= NOP_INSTR;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // sees the pre-edge values of state, pc and drop.
            case (state)
                S_IDLE: begin
                    state <= S_REQ;
                    if (redirect_valid) pc <= redirect_tgt;
                end

                S_REQ: begin
                    if (handshake) begin
                        req_pc <= pc;
                        drop   <= redirect_valid;
                        state  <= S_WAIT;
                    end
                    if (redirect_valid)  pc <= redirect_tgt;
                    else if (handshake)  pc <= pc_plus4;
                end

                S_WAIT: begin
                    if (redirect_valid) pc <= redirect_tgt;
                    if (imem_rsp_valid) begin
                        drop <= 1'b0;
                        if (!redirect_valid && !drop && stall) begin
                            buf_pc    <= req_pc;
                            buf_instr <= imem_rsp_data;
                            state     <= S_HOLD;
                        end else begin
                            state <= S_REQ;
                        end
                    end else if (redirect_valid) begin
                        drop <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (redirect_valid) begin
                        pc    <= redirect_tgt;
                        state <= S_REQ;
                    end else if (!stall) begin
                        state <= S_REQ;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // IF/ID slot: redirect > stall > new instruction > bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_valid      <= 1'b0;
            ifid_curr_instr <= NOP_INSTR;
            ifid_curr_pc    <= '0;
        end else if (redirect_valid) begin
            ifid_valid      <= 1'b0;
            ifid_curr_instr <= NOP_INSTR;
            ifid_curr_pc    <= '0;
        end else if (stall) begin
            ifid_valid      <= ifid_valid;
            ifid_curr_instr <= ifid_curr_instr;
            ifid_curr_pc    <= ifid_curr_pc;
        end else if (deliver_rsp) begin
            ifid_valid      <= 1'b1;
            ifid_curr_instr <= imem_rsp_data;
            ifid_curr_pc    <= req_pc;
        end else if (deliver_buf) begin
            ifid_valid      <= 1'b1;
            ifid_curr_instr <= buf_instr;
            ifid_curr_pc    <= buf_pc;
        end else begin
            ifid_valid      <= 1'b0;
            ifid_curr_instr <= NOP_INSTR;
        end
    end

endmodule
